// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide unit for the EX stage: 32-cycle shift-add / restoring-divide with HI/LO.
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU are accepted as no-ops.
`timescale 1ns/1ps
module mdu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        startE,
  input  logic [1:0]  mdOpE,
  input  logic [31:0] srcAE,
  input  logic [31:0] srcBE,
  input  logic        flushE,
  input  logic        mtE,
  input  logic        mtSelE,
  input  logic [31:0] mtDataE,
  output logic        stallE,
  output logic        busy,
  output logic [31:0] hiOut,
  output logic [31:0] loOut,
  output logic        divZero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_opnd;
  logic        r_neg_q;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_idle;
  logic        w_op_ok;
  logic        w_start;
  logic        w_signed;
  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_mul_sum;
  logic [63:0] w_step;
  logic [63:0] w_prod;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_idle   = (r_state == S_IDLE);
  assign w_signed = ~mdOpE[0];
  assign w_sa     = w_signed & srcAE[31];
  assign w_sb     = w_signed & srcBE[31];
  assign w_mag_a  = w_sa ? (32'd0 - srcAE) : srcAE;
  assign w_mag_b  = w_sb ? (32'd0 - srcBE) : srcBE;
  assign w_start  = w_idle & startE & ~flushE & w_op_ok;

  // Multiply: r_acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_prod    = r_neg_q ? (64'd0 - r_acc) : r_acc;

`ifdef MDU_DIV_EN
  logic        r_is_div;
  logic        r_neg_r;
  logic        r_zero;
  logic [32:0] w_div_shift;
  logic        w_div_ge;
  logic [31:0] w_div_rem;
  logic [63:0] w_div_next;

  // Divide: r_acc = {remainder, dividend bits then quotient bits}, shifted left each step.
  assign w_op_ok     = 1'b1;
  assign w_div_shift = r_acc[63:31];
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_rem   = w_div_shift[31:0] - r_opnd;
  assign w_div_next  = w_div_ge ? {w_div_rem, r_acc[30:0], 1'b1}
                                : {w_div_shift[31:0], r_acc[30:0], 1'b0};
  assign w_step      = r_is_div ? w_div_next : {w_mul_sum, r_acc[31:1]};
  assign divZero     = ~rst & (r_state == S_DONE) & r_zero & ~flushE;
`else
  assign w_op_ok = ~mdOpE[1];
  assign w_step  = {w_mul_sum, r_acc[31:1]};
  assign divZero = 1'b0;
`endif

  always_comb begin
    w_res_hi = w_prod[63:32];
    w_res_lo = w_prod[31:0];
`ifdef MDU_DIV_EN
    if (r_is_div) begin
      w_res_hi = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
      if (r_zero) w_res_lo = 32'hFFFF_FFFF;
      else        w_res_lo = r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_acc    <= 64'd0;
      r_opnd   <= 32'd0;
      r_neg_q  <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
`ifdef MDU_DIV_EN
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
      r_zero   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_BUSY;
            r_cnt    <= 5'd0;
            r_neg_q  <= w_sa ^ w_sb;
`ifdef MDU_DIV_EN
            r_is_div <= mdOpE[1];
            r_neg_r  <= w_sa;
            r_zero   <= mdOpE[1] & (srcBE == 32'd0);
            r_acc    <= {32'd0, mdOpE[1] ? w_mag_a : w_mag_b};
            r_opnd   <= mdOpE[1] ? w_mag_b : w_mag_a;
`else
            r_acc    <= {32'd0, w_mag_b};
            r_opnd   <= w_mag_a;
`endif
          end else if (!startE && mtE) begin
            if (mtSelE) r_hi <= mtDataE;
            else        r_lo <= mtDataE;
          end
        end
        S_BUSY: begin
          if (flushE) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // The instruction is still in EX here, so startE is ignored.
          r_state <= S_IDLE;
          if (!flushE) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // stallE holds IF/ID/EX from the accepting cycle through the last BUSY cycle; DONE releases it.
  assign stallE = ~rst & (w_start | ((r_state == S_BUSY) & ~flushE));
  assign busy   = (r_state == S_BUSY) | (r_state == S_DONE);
  assign hiOut  = r_hi;
  assign loOut  = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases, flush/reset/MTHI-MTLO scenarios and random ops
// against an arithmetic reference model. Works with or without MDU_DIV_EN.
`timescale 1ns/1ps
module tb_mdu_ctrl;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        startE;
  logic [1:0]  mdOpE;
  logic [31:0] srcAE;
  logic [31:0] srcBE;
  logic        flushE;
  logic        mtE;
  logic        mtSelE;
  logic [31:0] mtDataE;
  logic        stallE;
  logic        busy;
  logic [31:0] hiOut;
  logic [31:0] loOut;
  logic        divZero;

  int          errors;
  int          checks;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_ctrl dut (
    .clk(clk), .rst(rst), .startE(startE), .mdOpE(mdOpE), .srcAE(srcAE), .srcBE(srcBE),
    .flushE(flushE), .mtE(mtE), .mtSelE(mtSelE), .mtDataE(mtDataE), .stallE(stallE),
    .busy(busy), .hiOut(hiOut), .loOut(loOut), .divZero(divZero)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model: returns {HI, LO} ----------------
  function automatic logic [63:0] model_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 2'b00) begin
      p = sa * sb;
      return p;
    end
    if (op == 2'b01) begin
      u = {32'd0, a} * {32'd0, b};
      return u;
    end
    if (!DIV_EN) return cur;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == 2'b10) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // ---------------- driver: enter and leave just after a rising edge ----------------
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n_stall, output int n_busy, output int n_dz, output bit to);
    bit done_now;
    startE = 1'b1; mdOpE = op; srcAE = a; srcBE = b;
    n_stall = 0; n_busy = 0; n_dz = 0; to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stallE)  n_stall++;
      if (busy)    n_busy++;
      if (divZero) n_dz++;
      done_now = !stallE;
      @(posedge clk); #1;
      if (done_now) begin
        to = 1'b0;
        break;
      end
    end
    startE = 1'b0;
    @(negedge clk);
    if (busy)    n_busy++;
    if (divZero) n_dz++;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; startE = 1'b0; mdOpE = 2'b00; srcAE = '0; srcBE = '0;
    flushE = 1'b0; mtE = 1'b0; mtSelE = 1'b0; mtDataE = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (hiOut !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hiOut); end
    checks++; if (loOut !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", loOut); end
    checks++; if (stallE !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stallE); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (divZero !== 1'b0) begin errors++; $display("FAIL reset_divzero: got %b expected 0", divZero); end
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_mult();
    logic [1:0]  t_op [5];
    logic [31:0] t_a [5];
    logic [31:0] t_b [5];
    logic [63:0] t_e [5];
    logic [63:0] e;
    int ns, nb, nz;
    bit to;
    t_op = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
    t_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0};
    t_b  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
    t_e  = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFF1, 64'h4000_0000_0000_0000,
             64'hC000_0000_8000_0000, 64'd0};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(t_e[i]);
      run_op(t_op[i], t_a[i], t_b[i], ns, nb, nz, to);
      e = exp_q.pop_front();
      checks++; if (to) begin errors++; $display("FAIL mult_timeout[%0d]: stall never dropped", i); end
      checks++; if (ns != 33) begin errors++; $display("FAIL mult_stall[%0d]: got %0d expected 33", i, ns); end
      checks++; if (nb != 33) begin errors++; $display("FAIL mult_busy[%0d]: got %0d expected 33", i, nb); end
      checks++; if (nz != 0) begin errors++; $display("FAIL mult_divzero[%0d]: got %0d expected 0", i, nz); end
      checks++; if ({hiOut, loOut} !== e) begin
        errors++; $display("FAIL mult_result[%0d]: got %h expected %h", i, {hiOut, loOut}, e);
      end
      {m_hi, m_lo} = e;
    end
  endtask

  task automatic test_div();
    logic [1:0]  t_op [5];
    logic [31:0] t_a [5];
    logic [31:0] t_b [5];
    logic [63:0] t_e [5];
    int          t_z [5];
    logic [63:0] e;
    int ns, nb, nz, es;
    bit to;
`ifdef MDU_DIV_EN
    t_op = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b11};
    t_a  = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    t_b  = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd3};
    t_e  = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0064_FFFF_FFFF, 64'h0000_0000_8000_0000,
             64'hFFFF_FFF9_FFFF_FFFF, 64'h0000_0000_5555_5555};
    t_z  = '{0, 1, 0, 1, 0};
    es = 33;
`else
    t_op = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
    t_a  = '{32'd8, 32'd5, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
    t_b  = '{32'd2, 32'd0, 32'd2, 32'd7, 32'hFFFF_FFFF};
    t_e  = '{5{64'd0}};
    t_z  = '{0, 0, 0, 0, 0};
    es = 0;
`endif
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(DIV_EN ? t_e[i] : {m_hi, m_lo});
      run_op(t_op[i], t_a[i], t_b[i], ns, nb, nz, to);
      e = exp_q.pop_front();
      checks++; if (to) begin errors++; $display("FAIL div_timeout[%0d]: stall never dropped", i); end
      checks++; if (ns != es) begin errors++; $display("FAIL div_stall[%0d]: got %0d expected %0d", i, ns, es); end
      checks++; if (nb != es) begin errors++; $display("FAIL div_busy[%0d]: got %0d expected %0d", i, nb, es); end
      checks++; if (nz != t_z[i]) begin errors++; $display("FAIL div_divzero[%0d]: got %0d expected %0d", i, nz, t_z[i]); end
      checks++; if ({hiOut, loOut} !== e) begin
        errors++; $display("FAIL div_result[%0d]: got %h expected %h", i, {hiOut, loOut}, e);
      end
      {m_hi, m_lo} = e;
    end
  endtask

  task automatic test_mt();
    logic [31:0] d;
    bit done_now, to;
    mtE = 1'b1; mtSelE = 1'b0; mtDataE = 32'h0000_1234;
    @(posedge clk); #1;
    mtE = 1'b0; m_lo = 32'h0000_1234;
    checks++; if (loOut !== m_lo) begin errors++; $display("FAIL mt_lo: got %h expected %h", loOut, m_lo); end
    checks++; if (hiOut !== m_hi) begin errors++; $display("FAIL mt_lo_hi: got %h expected %h", hiOut, m_hi); end
    d = $urandom;
    mtE = 1'b1; mtSelE = 1'b1; mtDataE = d;
    @(posedge clk); #1;
    mtE = 1'b0; m_hi = d;
    checks++; if (hiOut !== m_hi) begin errors++; $display("FAIL mt_hi: got %h expected %h", hiOut, m_hi); end
    checks++; if (loOut !== m_lo) begin errors++; $display("FAIL mt_hi_lo: got %h expected %h", loOut, m_lo); end
    // start has priority over a simultaneous MTHI, and HI/LO hold during the operation
    mtE = 1'b1; mtSelE = 1'b1; mtDataE = 32'hDEAD_BEEF;
    startE = 1'b1; mdOpE = 2'b01; srcAE = 32'd6; srcBE = 32'd7;
    repeat (6) begin @(posedge clk); #1; end
    checks++; if ({hiOut, loOut} !== {m_hi, m_lo}) begin
      errors++; $display("FAIL mt_during_op: got %h expected %h", {hiOut, loOut}, {m_hi, m_lo});
    end
    mtE = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      done_now = !stallE;
      @(posedge clk); #1;
      if (done_now) begin to = 1'b0; break; end
    end
    startE = 1'b0;
    m_hi = 32'd0; m_lo = 32'd42;
    checks++; if (to) begin errors++; $display("FAIL mt_op_timeout: stall never dropped"); end
    checks++; if ({hiOut, loOut} !== {m_hi, m_lo}) begin
      errors++; $display("FAIL mt_op_result: got %h expected %h", {hiOut, loOut}, {m_hi, m_lo});
    end
  endtask

  task automatic test_flush_busy();
    startE = 1'b1; mdOpE = 2'b00; srcAE = 32'hFFFF_FFFD; srcBE = 32'd5;
    repeat (11) begin @(posedge clk); #1; end
    flushE = 1'b1;
    @(negedge clk);
    checks++; if (stallE !== 1'b0) begin errors++; $display("FAIL flush_busy_stall: got %b expected 0", stallE); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_inbusy: got %b expected 1", busy); end
    @(posedge clk); #1;
    flushE = 1'b0; startE = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_idle: got %b expected 0", busy); end
    checks++; if (stallE !== 1'b0) begin errors++; $display("FAIL flush_busy_stall2: got %b expected 0", stallE); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if ({hiOut, loOut} !== {m_hi, m_lo}) begin
      errors++; $display("FAIL flush_busy_hilo: got %h expected %h", {hiOut, loOut}, {m_hi, m_lo});
    end
  endtask

  task automatic test_flush_done();
    startE = 1'b1;
`ifdef MDU_DIV_EN
    mdOpE = 2'b11; srcAE = 32'd100; srcBE = 32'd0;
`else
    mdOpE = 2'b01; srcAE = $urandom; srcBE = $urandom;
`endif
    repeat (33) begin @(posedge clk); #1; end
    flushE = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_done_busy: got %b expected 1", busy); end
    checks++; if (stallE !== 1'b0) begin errors++; $display("FAIL flush_done_stall: got %b expected 0", stallE); end
    checks++; if (divZero !== 1'b0) begin errors++; $display("FAIL flush_done_divzero: got %b expected 0", divZero); end
    @(posedge clk); #1;
    flushE = 1'b0; startE = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_done_idle: got %b expected 0", busy); end
    checks++; if ({hiOut, loOut} !== {m_hi, m_lo}) begin
      errors++; $display("FAIL flush_done_hilo: got %h expected %h", {hiOut, loOut}, {m_hi, m_lo});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] e;
    int ns, nb, nz;
    bit to;
    startE = 1'b1; mdOpE = 2'b00; srcAE = $urandom; srcBE = $urandom;
    repeat (21) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (hiOut !== 32'd0) begin errors++; $display("FAIL rstmid_hi: got %h expected 0", hiOut); end
    checks++; if (loOut !== 32'd0) begin errors++; $display("FAIL rstmid_lo: got %h expected 0", loOut); end
    checks++; if (stallE !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b expected 0", stallE); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (divZero !== 1'b0) begin errors++; $display("FAIL rstmid_divzero: got %b expected 0", divZero); end
    m_hi = 32'd0; m_lo = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(64'd143);
    run_op(2'b01, 32'd11, 32'd13, ns, nb, nz, to);
    e = exp_q.pop_front();
    checks++; if (to || ns != 33) begin errors++; $display("FAIL rstmid_first_start: got stall %0d expected 33", ns); end
    checks++; if ({hiOut, loOut} !== e) begin
      errors++; $display("FAIL rstmid_result: got %h expected %h", {hiOut, loOut}, e);
    end
    {m_hi, m_lo} = e;
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, d;
    logic [63:0] e;
    int ns, nb, nz, es, ez;
    bit to;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        d = $urandom;
        mtSelE = 1'($urandom_range(0, 1)); mtDataE = d; mtE = 1'b1;
        @(posedge clk); #1;
        mtE = 1'b0;
        if (mtSelE) m_hi = d; else m_lo = d;
        checks++; if ({hiOut, loOut} !== {m_hi, m_lo}) begin
          errors++; $display("FAIL rand_mt[%0d]: got %h expected %h", i, {hiOut, loOut}, {m_hi, m_lo});
        end
      end
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 9);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      exp_q.push_back(model_op(op, a, b, {m_hi, m_lo}));
      es = (DIV_EN || !op[1]) ? 33 : 0;
      ez = (DIV_EN && op[1] && b == 32'd0) ? 1 : 0;
      run_op(op, a, b, ns, nb, nz, to);
      e = exp_q.pop_front();
      checks++; if (to) begin errors++; $display("FAIL rand_timeout[%0d]: stall never dropped", i); end
      checks++; if (ns != es || nb != es) begin
        errors++; $display("FAIL rand_stall_busy[%0d]: got %0d/%0d expected %0d", i, ns, nb, es);
      end
      checks++; if (nz != ez) begin errors++; $display("FAIL rand_divzero[%0d]: got %0d expected %0d", i, nz, ez); end
      checks++; if ({hiOut, loOut} !== e) begin
        errors++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, {hiOut, loOut}, e);
      end
      {m_hi, m_lo} = e;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_flush_busy();
    test_flush_done();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
